alu_cmd_sequencer: RTL and testbench

//  Upstream issue stage for the 4-bit combinational ALU.

---
 rtl/alu_seq_pkg.sv | 28 ++
 rtl/alu_seq_regfile.sv | 44 ++++
 rtl/alu_cmd_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// ----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU command sequencer: opcode encodings as seen on
// cmd_op / alu_sel, the sequencer state type, and a helper that says which
// opcodes update the sticky carry flag.
// No ports (package).
// ----------------------------------------------------------------------------
package alu_seq_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_LOAD = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Only arithmetic ops carry meaningful carry/borrow information.
    function automatic logic op_sets_carry(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// ----------------------------------------------------------------------------
// alu_seq_regfile
// NUM_REGS x DATA_W register file with two asynchronous read ports and one
// synchronous write port. Synchronous active-high reset clears every entry.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   rd_a_idx_i/rd_a_data_o read port A
//   rd_b_idx_i/rd_b_data_o read port B
//   we_i, wr_idx_i, wr_data_i  write port (takes effect on the rising edge)
// ----------------------------------------------------------------------------
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned IDX_W    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  rd_a_idx_i,
    output logic [DATA_W-1:0] rd_a_data_o,
    input  logic [IDX_W-1:0]  rd_b_idx_i,
    output logic [DATA_W-1:0] rd_b_data_o,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_a_data_o = mem_q[rd_a_idx_i];
    assign rd_b_data_o = mem_q[rd_b_idx_i];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// alu_cmd_sequencer
// Issue stage for an external 4-bit combinational ALU. Accepts one
// register-addressed command at a time, drives registered operands/select to
// the ALU, captures its result one cycle later, writes it back to the register
// file and presents it on a valid/ready result stream.
// FSM: S_IDLE (accept) -> S_EXEC (capture/writeback) -> S_RESP (hold result).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_imm   command fields
//   alu_a, alu_b, alu_sel         registered ALU operands and select
//   alu_out, alu_carry            ALU result inputs
//   res_valid/res_ready           result handshake
//   res_data, res_carry, res_dst  result fields, stable while res_valid
//   carry_flag                    sticky carry of the last ADD/SUB
//   res_zero                      result==0 (only with ALU_SEQ_ZERO_FLAG_EN)
// Build option: define ALU_SEQ_ZERO_FLAG_EN to add the res_zero output.
// ----------------------------------------------------------------------------
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [IDX_W-1:0]  cmd_src_a,
    input  logic [IDX_W-1:0]  cmd_src_b,
    input  logic [IDX_W-1:0]  cmd_dst,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_carry,
    output logic [IDX_W-1:0]  res_dst,
    output logic              carry_flag
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic              res_zero
`endif
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [2:0]        alu_sel_q, alu_sel_d;
    logic [IDX_W-1:0]  dst_q, dst_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_carry_q, res_carry_d;
    logic [IDX_W-1:0]  res_dst_q, res_dst_d;
    logic              carry_flag_q, carry_flag_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic              res_zero_q, res_zero_d;
`endif

    logic [DATA_W-1:0] rf_rd_a, rf_rd_b;
    logic [DATA_W-1:0] exec_result;
    logic              exec_carry;
    logic              rf_we;

    // LOAD bypasses the ALU; every other op (reserved included) takes its output.
    assign exec_result = (alu_sel_q == OP_LOAD) ? imm_q : alu_out;
    assign exec_carry  = (alu_sel_q == OP_LOAD) ? 1'b0 : alu_carry;
    assign rf_we       = (state_q == S_EXEC);

    alu_seq_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk_i       (clk),
        .rst_i       (rst),
        .rd_a_idx_i  (cmd_src_a),
        .rd_a_data_o (rf_rd_a),
        .rd_b_idx_i  (cmd_src_b),
        .rd_b_data_o (rf_rd_b),
        .we_i        (rf_we),
        .wr_idx_i    (dst_q),
        .wr_data_i   (exec_result)
    );

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        dst_d        = dst_q;
        imm_d        = imm_q;
        res_data_d   = res_data_q;
        res_carry_d  = res_carry_q;
        res_dst_d    = res_dst_q;
        carry_flag_d = carry_flag_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        res_zero_d   = res_zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    // Operands are read here, so src==dst sees the old value.
                    alu_a_d   = rf_rd_a;
                    alu_b_d   = rf_rd_b;
                    alu_sel_d = cmd_op;
                    dst_d     = cmd_dst;
                    imm_d     = cmd_imm;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                res_data_d  = exec_result;
                res_carry_d = exec_carry;
                res_dst_d   = dst_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                res_zero_d  = (exec_result == '0);
`endif
                if (op_sets_carry(alu_sel_q)) begin
                    carry_flag_d = exec_carry;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            dst_q        <= '0;
            imm_q        <= '0;
            res_data_q   <= '0;
            res_carry_q  <= 1'b0;
            res_dst_q    <= '0;
            carry_flag_q <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            res_zero_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            dst_q        <= dst_d;
            imm_q        <= imm_d;
            res_data_q   <= res_data_d;
            res_carry_q  <= res_carry_d;
            res_dst_q    <= res_dst_d;
            carry_flag_q <= carry_flag_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            res_zero_q   <= res_zero_d;
`endif
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign res_valid  = (state_q == S_RESP);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign res_data   = res_data_q;
    assign res_carry  = res_carry_q;
    assign res_dst    = res_dst_q;
    assign carry_flag = carry_flag_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    assign res_zero   = res_zero_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Bench for alu_cmd_sequencer with a behavioural 4-bit ALU beside it.
// Directed commands push their hand-computed result into a queue; a monitor
// pops and compares whenever a result is handed over on res_valid/res_ready.
// ----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    typedef struct {
        logic [3:0] data;
        logic       carry;
        logic [1:0] dst;
        logic       zero;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_src_a, cmd_src_b, cmd_dst;
    logic [3:0] cmd_imm;
    logic [3:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_sel;
    logic       alu_carry;
    logic       res_valid, res_ready;
    logic [3:0] res_data;
    logic       res_carry;
    logic [1:0] res_dst;
    logic       carry_flag;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic       res_zero;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .DATA_W   (4),
        .NUM_REGS (4),
        .IDX_W    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_src_a  (cmd_src_a),
        .cmd_src_b  (cmd_src_b),
        .cmd_dst    (cmd_dst),
        .cmd_imm    (cmd_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_carry  (res_carry),
        .res_dst    (res_dst),
        .carry_flag (carry_flag)
`ifdef ALU_SEQ_ZERO_FLAG_EN
        ,
        .res_zero   (res_zero)
`endif
    );

    // Reference 4-bit ALU; SUB carry-out is the borrow.
    logic [4:0] alu_wide;
    always_comb begin
        alu_wide = 5'd0;
        case (alu_sel)
            OP_AND:  alu_wide = {1'b0, alu_a & alu_b};
            OP_OR:   alu_wide = {1'b0, alu_a | alu_b};
            OP_NOT:  alu_wide = {1'b0, ~alu_a};
            OP_ADD:  alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
            default: alu_wide = 5'd0;
        endcase
    end
    assign alu_out   = alu_wide[3:0];
    assign alu_carry = alu_wide[4];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic summary_and_finish();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic abort(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout, got no DUT response, required one", name);
        summary_and_finish();
    endtask

    // Monitor: a result transfers at the next rising edge when valid & ready.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got data %0d, required no result", res_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("res_data", int'(res_data), int'(mon_e.data));
                check("res_carry", int'(res_carry), int'(mon_e.carry));
                check("res_dst", int'(res_dst), int'(mon_e.dst));
`ifdef ALU_SEQ_ZERO_FLAG_EN
                check("res_zero", int'(res_zero), int'(mon_e.zero));
`endif
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [1:0] dst, input logic [3:0] imm,
                         input logic [3:0] ed, input logic ec, input bit push);
        bit ok;
        exp_t e;
        if (push) begin
            e.data  = ed;
            e.carry = ec;
            e.dst   = dst;
            e.zero  = (ed == 4'd0);
            exp_q.push_back(e);
        end
        cmd_op    = op;
        cmd_src_a = sa;
        cmd_src_b = sb;
        cmd_dst   = dst;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) abort("cmd_accept");
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) abort("result_done");
    endtask

    task automatic run(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [1:0] dst, input logic [3:0] imm,
                       input logic [3:0] ed, input logic ec);
        issue(op, sa, sb, dst, imm, ed, ec, 1'b1);
        wait_done();
    endtask

    initial begin
        #100000;
        abort("watchdog");
    end

    initial begin
        bit ok;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_src_a = 2'd0;
        cmd_src_b = 2'd0;
        cmd_dst   = 2'd0;
        cmd_imm   = 4'd0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_data", int'(res_data), 0);
        check("rst_carry_flag", int'(carry_flag), 0);
        check("rst_alu_sel", int'(alu_sel), 0);

        // 1. LOAD r0=9, r1=8, ADD r2 = 17 mod 16 = 1 with carry; check latency
        run(OP_LOAD, 2'd0, 2'd0, 2'd0, 4'd9, 4'd9, 1'b0);
        run(OP_LOAD, 2'd0, 2'd0, 2'd1, 4'd8, 4'd8, 1'b0);
        issue(OP_ADD, 2'd0, 2'd1, 2'd2, 4'd0, 4'd1, 1'b1, 1'b1);
        check("lat_exec_res_valid", int'(res_valid), 0);
        @(posedge clk);
        #1 check("lat_resp_res_valid", int'(res_valid), 1);
        wait_done();
        check("add_carry_flag", int'(carry_flag), 1);

        // 2. LOAD r0=3, r1=5 (flag untouched), SUB r3 = 3-5 = 14 with borrow, AND = 1
        run(OP_LOAD, 2'd0, 2'd0, 2'd0, 4'd3, 4'd3, 1'b0);
        run(OP_LOAD, 2'd0, 2'd0, 2'd1, 4'd5, 4'd5, 1'b0);
        check("load_keeps_flag", int'(carry_flag), 1);
        run(OP_SUB, 2'd0, 2'd1, 2'd3, 4'd0, 4'd14, 1'b1);
        run(OP_AND, 2'd0, 2'd1, 2'd2, 4'd0, 4'd1, 1'b0);
        check("and_keeps_flag", int'(carry_flag), 1);

        // 3. Back-pressure: OR r2 = 3|5 = 7 held for 5 cycles, pulsed cmd ignored
        res_ready = 1'b0;
        issue(OP_OR, 2'd0, 2'd1, 2'd2, 4'd0, 4'd7, 1'b0, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) abort("resp_valid");
        for (int h = 0; h < 5; h++) begin
            check("hold_res_valid", int'(res_valid), 1);
            check("hold_res_data", int'(res_data), 7);
            check("hold_res_dst", int'(res_dst), 2);
            check("hold_cmd_ready", int'(cmd_ready), 0);
            if (h == 1) begin
                cmd_op    = OP_LOAD;
                cmd_dst   = 2'd0;
                cmd_imm   = 4'd15;
                cmd_valid = 1'b1;
            end
            if (h == 2) cmd_valid = 1'b0;
            @(negedge clk);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        wait_done();
        run(OP_OR, 2'd0, 2'd0, 2'd3, 4'd0, 4'd3, 1'b0);
        check("or_keeps_flag", int'(carry_flag), 1);

        // 4. Reset during EXEC of LOAD r1=7: dropped, everything cleared
        issue(OP_LOAD, 2'd0, 2'd0, 2'd1, 4'd7, 4'd0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_exec_cmd_ready", int'(cmd_ready), 1);
        check("rst_exec_res_valid", int'(res_valid), 0);
        check("rst_exec_carry_flag", int'(carry_flag), 0);
        check("rst_exec_res_data", int'(res_data), 0);
        run(OP_OR, 2'd1, 2'd1, 2'd0, 4'd0, 4'd0, 1'b0);

        // 5. Reserved op gives 0 and writes 0; NOT 15 with src==dst gives 0
        run(OP_LOAD, 2'd0, 2'd0, 2'd0, 4'd15, 4'd15, 1'b0);
        run(OP_LOAD, 2'd0, 2'd0, 2'd2, 4'd6, 4'd6, 1'b0);
        run(3'b101, 2'd0, 2'd0, 2'd2, 4'd0, 4'd0, 1'b0);
        run(OP_OR, 2'd2, 2'd2, 2'd3, 4'd0, 4'd0, 1'b0);
        run(OP_NOT, 2'd0, 2'd0, 2'd0, 4'd0, 4'd0, 1'b0);
        run(OP_OR, 2'd0, 2'd0, 2'd1, 4'd0, 4'd0, 1'b0);
        check("reserved_keeps_flag", int'(carry_flag), 0);

        // 6. AND 0xA & 0x5 = 0 (zero flag set), OR = 15 (zero flag clear)
        run(OP_LOAD, 2'd0, 2'd0, 2'd0, 4'hA, 4'hA, 1'b0);
        run(OP_LOAD, 2'd0, 2'd0, 2'd1, 4'h5, 4'h5, 1'b0);
        run(OP_AND, 2'd0, 2'd1, 2'd2, 4'd0, 4'd0, 1'b0);
        run(OP_OR, 2'd0, 2'd1, 2'd3, 4'd0, 4'd15, 1'b0);

        // ADD without carry clears the sticky flag after SUB sets it
        run(OP_SUB, 2'd1, 2'd0, 2'd2, 4'd0, 4'd11, 1'b1);
        check("sub_sets_flag", int'(carry_flag), 1);
        run(OP_ADD, 2'd1, 2'd1, 2'd2, 4'd0, 4'd10, 1'b0);
        check("add_clears_flag", int'(carry_flag), 0);

        check("queue_empty", exp_q.size(), 0);
        summary_and_finish();
    end

endmodule
